// File: rtl/mips_define.sv
// Shared MIPS pipeline encodings: PC source select and IF fetch FSM states.
package mips_define;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_HOLD  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; low bits of any target are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: live redirect from ID, then pending redirect, then pc+4.
module next_pc_sel
    import mips_define::*;
(
    input  logic [31:0] pc,
    input  logic        if_valid,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic        redir_v,
    input  logic [31:0] redir_tgt,
    output logic        live_redir,
    output logic [31:0] live_tgt,
    output logic [31:0] next_pc
);

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        live_redir = 1'b0;
        live_tgt   = '0;
        next_pc    = pc + 32'd4;

        if (if_valid && pc_src == PC_JUMP) begin
            live_redir = 1'b1;
            live_tgt   = align_word(jump_target);
        end else if (if_valid && pc_src == PC_BRANCH) begin
            live_redir = 1'b1;
            live_tgt   = align_word(branch_target);
        end

        if (live_redir) begin
            next_pc = live_tgt;
        end else if (redir_v) begin
            next_pc = redir_tgt;
        end
    end

endmodule

// File: rtl/inst_fetch_stage.sv
// MIPS IF stage: owns the PC, handshakes with instruction memory, drives IF/ID.
module inst_fetch_stage
    import mips_define::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_rst,
    input  logic        if_en,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        if_valid,
    output logic        fetch_stall
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  hb;
    logic         hb_v;
    logic         redir_v;
    logic [31:0]  redir_tgt;
    logic [31:0]  drain_addr;

    logic         avail;
    logic [31:0]  avail_inst;
    logic         live_redir;
    logic [31:0]  live_tgt;
    logic [31:0]  next_pc;

    next_pc_sel u_next_pc_sel (
        .pc            (pc),
        .if_valid      (if_valid),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .redir_v       (redir_v),
        .redir_tgt     (redir_tgt),
        .live_redir    (live_redir),
        .live_tgt      (live_tgt),
        .next_pc       (next_pc)
    );

    // DRAIN keeps presenting the abandoned address until memory answers it.
    assign imem_req  = ~rst & (state != FETCH_HOLD);
    assign imem_addr = (state == FETCH_DRAIN) ? drain_addr : pc;

    assign avail       = ~rst & (((state == FETCH_REQ) & imem_ack) |
                                 ((state == FETCH_HOLD) & hb_v));
    assign avail_inst  = (state == FETCH_HOLD) ? hb : imem_data;
    assign fetch_stall = if_en & ~avail;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= FETCH_REQ;
            pc         <= PC_RESET;
            if_valid   <= 1'b0;
            hb_v       <= 1'b0;
            redir_v    <= 1'b0;
            id_inst    <= '0;
            id_pc      <= '0;
            hb         <= '0;
            redir_tgt  <= '0;
            drain_addr <= '0;
        end else if (if_rst) begin
            pc       <= PC_RESET;
            if_valid <= 1'b0;
            hb_v     <= 1'b0;
            redir_v  <= 1'b0;
            if (state == FETCH_REQ && !imem_ack) begin
                state      <= FETCH_DRAIN;
                drain_addr <= pc;
            end else if (state == FETCH_DRAIN && !imem_ack) begin
                state <= FETCH_DRAIN;
            end else begin
                state <= FETCH_REQ;
            end
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (imem_ack && !if_en) begin
                        hb    <= imem_data;
                        hb_v  <= 1'b1;
                        state <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (if_en) begin
                        hb_v  <= 1'b0;
                        state <= FETCH_REQ;
                    end
                end
                FETCH_DRAIN: begin
                    if (imem_ack) begin
                        state <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_REQ;
            endcase

            if (if_en) begin
                if (avail) begin
                    id_inst  <= avail_inst;
                    id_pc    <= pc;
                    if_valid <= 1'b1;
                    pc       <= next_pc;
                    redir_v  <= 1'b0;
                end else begin
                    if_valid <= 1'b0;
                    // The branch leaves ID on a bubble; keep its target for the delay slot.
                    if (live_redir) begin
                        redir_v   <= 1'b1;
                        redir_tgt <= live_tgt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Randomized bench for inst_fetch_stage against a transaction-level IF model.
module tb_inst_fetch_stage;

    localparam logic [31:0] PC_RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_rst;
    logic        if_en;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        if_valid;
    logic        fetch_stall;

    always #5 clk = ~clk;

    inst_fetch_stage #(.PC_RESET(PC_RST)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_rst        (if_rst),
        .if_en         (if_en),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .if_valid      (if_valid),
        .fetch_stall   (fetch_stall)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: IF/ID contents, next fetch address, held and pending-redirect queues.
    logic [31:0] m_pc, m_id_inst, m_id_pc, m_drain_addr;
    bit          m_valid, m_draining;
    logic [31:0] held_q[$];
    logic [31:0] redir_q[$];

    // Memory model: random latency per request.
    bit mem_busy;
    int mem_left;

    // Directed overrides for one cycle (-1 = none).
    int          f_src  = -1;
    logic [31:0] f_tgt  = '0;
    int          f_irst = 0;
    int          f_en   = -1;

    task automatic model_reset();
        m_pc       = PC_RST;
        m_valid    = 0;
        m_id_inst  = '0;
        m_id_pc    = '0;
        m_draining = 0;
        held_q.delete();
        redir_q.delete();
        mem_busy   = 0;
    endtask

    task automatic run_cycle(input int wmode, input int en_pct, input int src_pct,
                             input int irst_pct, input int rst_pct);
        bit          exp_req, avail, got, live, requesting;
        logic [31:0] inst, tgt;
        @(negedge clk);
        check("id_inst", id_inst, m_id_inst);
        check("id_pc", id_pc, m_id_pc);
        check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});

        rst           = ($urandom_range(99) < rst_pct);
        if_rst        = (f_irst != 0) || ($urandom_range(99) < irst_pct);
        if_en         = (f_en >= 0) ? (f_en != 0) : ($urandom_range(99) < en_pct);
        pc_src        = ($urandom_range(99) < src_pct) ? 2'($urandom_range(3)) : 2'd0;
        branch_target = $urandom;
        jump_target   = $urandom;
        if (f_src >= 0) begin
            pc_src        = 2'(f_src);
            branch_target = f_tgt;
            jump_target   = f_tgt;
        end
        #1;
        exp_req = !rst && held_q.size() == 0;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, m_draining ? m_drain_addr : m_pc);

        imem_ack  = 1'b0;
        imem_data = $urandom;
        if (rst) begin
            mem_busy = 0;
            imem_ack = 1'($urandom_range(1));
        end else if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_left = (wmode == 0) ? 0 : (wmode == 1) ? 2 : $urandom_range(3);
            end
            if (mem_left == 0) begin
                imem_ack = 1'b1;
                mem_busy = 0;
            end else begin
                mem_left--;
            end
        end
        #1;
        avail = !rst && !m_draining && (held_q.size() > 0 || imem_ack);
        check("fetch_stall", {31'b0, fetch_stall}, {31'b0, if_en && !avail});

        if (rst) begin
            model_reset();
        end else if (if_rst) begin
            requesting = held_q.size() == 0;
            if (requesting && !imem_ack) begin
                if (!m_draining) m_drain_addr = m_pc;
                m_draining = 1;
            end else begin
                m_draining = 0;
            end
            m_pc    = PC_RST;
            m_valid = 0;
            held_q.delete();
            redir_q.delete();
        end else begin
            got = 0;
            inst = '0;
            if (m_draining) begin
                if (imem_ack) m_draining = 0;
            end else if (held_q.size() > 0) begin
                if (if_en) begin
                    inst = held_q.pop_front();
                    got  = 1;
                end
            end else if (imem_ack) begin
                if (if_en) begin
                    inst = imem_data;
                    got  = 1;
                end else begin
                    held_q.push_back(imem_data);
                end
            end
            live = m_valid && (pc_src == 2'd1 || pc_src == 2'd2);
            tgt  = ((pc_src == 2'd1) ? jump_target : branch_target) & ~32'h3;
            if (if_en) begin
                if (got) begin
                    m_id_inst = inst;
                    m_id_pc   = m_pc;
                    m_valid   = 1;
                    if (live) m_pc = tgt;
                    else if (redir_q.size() > 0) m_pc = redir_q[0];
                    else m_pc = m_pc + 32'd4;
                    redir_q.delete();
                end else begin
                    m_valid = 0;
                    if (live) begin
                        redir_q.delete();
                        redir_q.push_back(tgt);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; if_rst = 1'b0; if_en = 1'b1; pc_src = 2'd0;
        branch_target = '0; jump_target = '0; imem_ack = 1'b0; imem_data = '0;
        model_reset();
        repeat (2) run_cycle(0, 100, 0, 0, 100);

        // Reset values and the first request right after rst falls.
        @(posedge clk); #1;
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
        rst = 1'b0;
        #1;
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, PC_RST);

        // Zero-wait streaming, then a branch to 0x100 with its delay slot.
        repeat (3) run_cycle(0, 100, 0, 0, 0);
        f_src = 2; f_tgt = 32'h0000_0100;
        run_cycle(0, 100, 0, 0, 0);
        f_src = -1;
        repeat (4) run_cycle(0, 100, 0, 0, 0);

        // 2-wait memory, and a branch arriving during a bubble.
        repeat (7) run_cycle(1, 100, 0, 0, 0);
        f_src = 2; f_tgt = 32'h0000_0203;
        run_cycle(1, 100, 0, 0, 0);
        f_src = -1;
        repeat (9) run_cycle(1, 100, 0, 0, 0);

        // Ack while disabled: HOLD for 3 cycles, then release.
        f_en = 0;
        repeat (3) run_cycle(0, 100, 0, 0, 0);
        f_en = -1;
        repeat (4) run_cycle(0, 100, 0, 0, 0);

        // if_rst with a request outstanding (drain), then streaming again.
        run_cycle(1, 100, 0, 0, 0);
        f_irst = 1;
        run_cycle(1, 100, 0, 0, 0);
        f_irst = 0;
        repeat (8) run_cycle(1, 100, 0, 0, 0);

        // PC wrap: jump to the top word of the address space.
        run_cycle(0, 100, 0, 0, 0);
        f_src = 1; f_tgt = 32'hFFFF_FFFF;
        run_cycle(0, 100, 0, 0, 0);
        f_src = -1;
        repeat (4) run_cycle(0, 100, 0, 0, 0);

        // Fully randomized traffic.
        for (int i = 0; i < 3000; i++) run_cycle(2, 80, 30, 3, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
